coco_mem_mapper: RTL



---
 rtl/coco_mem_pkg.sv | 35 +++
 rtl/coco_unlock_fsm.sv | 69 ++++++
 rtl/coco_mem_mapper.sv | 115 +++++++++++
 3 files changed

// File: rtl/coco_mem_pkg.sv
// Shared constants and types for the CoCo cartridge memory mapper.
package coco_mem_pkg;

  // Register offsets relative to REG_BASE
  localparam logic [2:0] OffBank0  = 3'd0;
  localparam logic [2:0] OffBank1  = 3'd1;
  localparam logic [2:0] OffBank2  = 3'd2;
  localparam logic [2:0] OffBank3  = 3'd3;
  localparam logic [2:0] OffMode   = 3'd4;
  localparam logic [2:0] OffUnlock = 3'd5;
  localparam logic [2:0] OffStatus = 3'd6;
  localparam logic [2:0] OffId     = 3'd7;

  localparam logic [1:0] MemOff   = 2'b00;
  localparam logic [1:0] MemRom   = 2'b01;
  localparam logic [1:0] MemRoRam = 2'b10;
  localparam logic [1:0] MemRwRam = 2'b11;

  localparam logic [7:0] KeyK1     = 8'h55;
  localparam logic [7:0] KeyK2     = 8'hAA;
  localparam logic [7:0] KeyArm    = 8'hC3;
  localparam logic [7:0] KeyDisarm = 8'h00;

  localparam logic [3:0] FAM_RI  = 4'hC;
  localparam logic [3:0] ID_CMM  = 4'h5;
  localparam logic [7:0] VER_CMM = 8'h01;

  typedef enum logic [1:0] {
    StIdle,
    StK1,
    StK2,
    StArmed
  } unlock_state_e;

endpackage

// File: rtl/coco_unlock_fsm.sv
// Flash program-arm sequencer: three-key unlock followed by a write-refreshed timeout.
module coco_unlock_fsm
  import coco_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic                    clock,
  input  logic                    _reset,
  input  logic                    reg_wr,
  input  logic                    unlock_wr,
  input  logic [7:0]              wdata,
  input  logic                    flash_wr,
  output logic                    armed,
  output logic [TIMEOUT_BITS-1:0] counter
);

  unlock_state_e           state_q, state_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (unlock_wr && wdata == KeyK1) state_d = StK1;
      end
      StK1: begin
        if (unlock_wr && wdata == KeyK2) state_d = StK2;
        else if (reg_wr)                 state_d = StIdle;
      end
      StK2: begin
        if (unlock_wr && wdata == KeyArm) begin
          state_d = StArmed;
          cnt_d   = '1;
        end else if (reg_wr) begin
          state_d = StIdle;
        end
      end
      StArmed: begin
        // A flash write on the expiring edge still refreshes the window.
        if (unlock_wr && wdata == KeyDisarm) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (flash_wr) begin
          cnt_d = '1;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - TIMEOUT_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign armed   = (state_q == StArmed);
  assign counter = cnt_q;

endmodule

// File: rtl/coco_mem_mapper.sv
// Multi-window banked cartridge mapper with register block and write-protected flash.
module coco_mem_mapper
  import coco_mem_pkg::*;
#(
  parameter int unsigned BANK_BITS    = 7,
  parameter int unsigned WIN_BITS     = 1,
  parameter logic [5:0]  REG_BASE     = 6'h18,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic                 clock,
  input  logic                 _reset,
  input  logic [15:0]          address,
  inout  wire  [7:0]           data,
  input  logic                 r_w,
  input  logic                 _cts,
  input  logic                 _scs,
  input  logic                 _rom_enable,
  output logic [BANK_BITS-1:0] baddress,
  output logic                 _ce_flash,
  output logic                 _ce_sram,
  output logic                 _we,
  output logic                 _cts_out
);

  localparam int unsigned NWin = 1 << WIN_BITS;
  localparam int unsigned ShL  = (TIMEOUT_BITS < 7) ? 7 - TIMEOUT_BITS : 0;
  localparam int unsigned ShR  = (TIMEOUT_BITS > 7) ? TIMEOUT_BITS - 7 : 0;

  logic [BANK_BITS-1:0]    bank_q [4];
  logic [1:0]              mem_type_q;
  logic                    memset_q;

  logic [5:0]              reg_diff;
  logic [2:0]              reg_off;
  logic                    reg_hit, reg_wr, reg_rd, unlock_wr;
  logic [1:0]              win;
  logic                    armed, flash_wr;
  logic [TIMEOUT_BITS-1:0] counter;
  logic [6:0]              cnt_msb;
  logic [7:0]              rdata;
  logic                    rd_flash, rd_sram, wr_flash, wr_sram, any_ce;
  logic                    unused_addr;

  // Block is 8 registers starting at REG_BASE inside the SCS page.
  assign reg_diff  = address[5:0] - REG_BASE;
  assign reg_off   = reg_diff[2:0];
  assign reg_hit   = !_scs && (reg_diff[5:3] == 3'b000);
  assign reg_wr    = reg_hit && !r_w;
  assign reg_rd    = reg_hit && r_w;
  assign unlock_wr = reg_wr && (reg_off == OffUnlock);

  assign win         = 2'(address[13:12] >> (2 - WIN_BITS));
  assign baddress    = bank_q[win];
  assign unused_addr = ^{address[15:14], address[11:6]};

  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      for (int i = 0; i < 4; i++) bank_q[i] <= '0;
      mem_type_q <= MemOff;
      memset_q   <= 1'b0;
    end else if (reg_wr) begin
      if (!reg_off[2] && (32'(reg_off) < NWin)) bank_q[reg_off[1:0]] <= BANK_BITS'(data);
      if (reg_off == OffMode) begin
        mem_type_q <= data[1:0];
        memset_q   <= 1'b1;
      end
    end
  end

  assign rd_flash = !_cts && r_w &&
                    ((mem_type_q == MemRom) || (!memset_q && !_rom_enable));
  assign rd_sram  = !_cts && r_w && mem_type_q[1];
  assign wr_sram  = !_cts && !r_w && (mem_type_q == MemRwRam);
  assign wr_flash = !_cts && !r_w && (mem_type_q == MemRom) && armed;
  assign flash_wr = wr_flash;
  assign any_ce   = rd_flash || rd_sram || wr_flash || wr_sram;

  assign _ce_flash = !(rd_flash || wr_flash);
  assign _ce_sram  = !(rd_sram || wr_sram);
  assign _we       = any_ce ? r_w : 1'b1;
  assign _cts_out  = _cts || any_ce;

  coco_unlock_fsm #(
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) u_unlock (
    .clock    (clock),
    ._reset   (_reset),
    .reg_wr   (reg_wr),
    .unlock_wr(unlock_wr),
    .wdata    (data),
    .flash_wr (flash_wr),
    .armed    (armed),
    .counter  (counter)
  );

  // Top seven counter bits, zero-padded below when the counter is narrower.
  assign cnt_msb = 7'(({7'b0, counter} << ShL) >> ShR);

  always_comb begin
    rdata = 8'h00;
    unique case (reg_off)
      OffBank0, OffBank1, OffBank2, OffBank3: begin
        if (32'(reg_off) < NWin) rdata = 8'(bank_q[reg_off[1:0]]);
      end
      OffMode:   rdata = {memset_q, 5'b00000, mem_type_q};
      OffUnlock: rdata = 8'h00;
      OffStatus: rdata = {armed, cnt_msb};
      OffId:     rdata = {FAM_RI, ID_CMM};
      default:   rdata = 8'h00;
    endcase
  end

  assign data = (clock && reg_rd) ? rdata : 8'bz;

endmodule
